// File: rtl/tile_config_loader_if.sv
// Bitstream handshake and configuration bus between a bitstream source and
// tile_config_loader.
interface tile_config_loader_if #(
   parameter int unsigned CONFIG_WIDTH = 524,
   parameter int unsigned WORD_WIDTH   = 8
);
   logic                    start;
   logic [WORD_WIDTH-1:0]   data_in;
   logic                    data_valid;
   logic                    data_ready;
   logic [CONFIG_WIDTH-1:0] config_out;
   logic                    busy;
   logic                    done;
   logic                    error;

   modport master (
      output start, data_in, data_valid,
      input  data_ready, config_out, busy, done, error
   );

   modport slave (
      input  start, data_in, data_valid,
      output data_ready, config_out, busy, done, error
   );
endinterface

// File: rtl/tile_config_loader.sv
// Loads a word-serial bitstream into a shadow register, verifies an XOR checksum
// and only then commits it atomically to the tile configuration output.
module tile_config_loader #(
   parameter int unsigned CONFIG_WIDTH = 524,
   parameter int unsigned WORD_WIDTH   = 8
) (
   input  logic          clock,
   input  logic          nreset,
   tile_config_loader_if.slave bus
);

   localparam int unsigned NUM_WORDS = (CONFIG_WIDTH + WORD_WIDTH - 1) / WORD_WIDTH;
   localparam int unsigned CNT_W     = $clog2(NUM_WORDS + 1);
   localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NUM_WORDS - 1);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_LOAD  = 2'd1,
      ST_CHECK = 2'd2
   } state_e;

   state_e                  state_q, state_d;
   logic [CNT_W-1:0]        cnt_q, cnt_d;
   logic [WORD_WIDTH-1:0]   xor_q, xor_d;
   logic [CONFIG_WIDTH-1:0] config_q, config_d;
   logic [CONFIG_WIDTH-1:0] shadow_q, shadow_d;
   logic                    done_q, done_d;
   logic                    error_q, error_d;
   logic                    ready_c;
   logic                    accept_c;
   logic                    load_word_c;

   assign ready_c  = (state_q == ST_LOAD) || (state_q == ST_CHECK);
   assign accept_c = bus.data_valid && ready_c;

   // Next-state and datapath control; start always wins over a presented word.
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      xor_d       = xor_q;
      config_d    = config_q;
      done_d      = 1'b0;
      error_d     = error_q;
      load_word_c = 1'b0;

      if (bus.start) begin
         state_d = ST_LOAD;
         cnt_d   = '0;
         xor_d   = '0;
         error_d = 1'b0;
      end else begin
         unique case (state_q)
            ST_IDLE: ;
            ST_LOAD: begin
               if (accept_c) begin
                  load_word_c = 1'b1;
                  xor_d       = xor_q ^ bus.data_in;
                  cnt_d       = cnt_q + CNT_W'(1);
                  if (cnt_q == LAST_IDX) begin
                     state_d = ST_CHECK;
                  end
               end
            end
            ST_CHECK: begin
               if (accept_c) begin
                  state_d = ST_IDLE;
                  if (bus.data_in == xor_q) begin
                     config_d = shadow_q;
                     done_d   = 1'b1;
                  end else begin
                     error_d  = 1'b1;
                  end
               end
            end
            default: state_d = ST_IDLE;
         endcase
      end
   end

   // One shadow segment per word; the final segment keeps only the in-range bits.
   for (genvar k = 0; k < NUM_WORDS; k++) begin : g_seg
      localparam int unsigned LO  = k * WORD_WIDTH;
      localparam int unsigned SEG = ((CONFIG_WIDTH - LO) < WORD_WIDTH) ? (CONFIG_WIDTH - LO)
                                                                      : WORD_WIDTH;
      assign shadow_d[LO +: SEG] = (load_word_c && (cnt_q == CNT_W'(k)))
                                   ? bus.data_in[SEG-1:0]
                                   : shadow_q[LO +: SEG];
   end

   // Shadow contents are always fully rewritten before a commit, so no reset.
   always_ff @(posedge clock) begin
      shadow_q <= shadow_d;
   end

   always_ff @(posedge clock) begin
      if (!nreset) begin
         state_q  <= ST_IDLE;
         cnt_q    <= '0;
         xor_q    <= '0;
         config_q <= '0;
         done_q   <= 1'b0;
         error_q  <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         xor_q    <= xor_d;
         config_q <= config_d;
         done_q   <= done_d;
         error_q  <= error_d;
      end
   end

   assign bus.data_ready = ready_c;
   assign bus.busy       = ready_c;
   assign bus.config_out = config_q;
   assign bus.done       = done_q;
   assign bus.error      = error_q;

endmodule

// File: tb/tb_tile_config_loader.sv
// Directed bench for tile_config_loader: table of full loads plus hand-written
// abort, reset and start-collision sequences.
module tb_tile_config_loader;

   localparam int unsigned CW = 524;
   localparam int unsigned WW = 8;
   localparam int unsigned NW = 66;
   localparam int unsigned PW = NW * WW;

   typedef struct {
      logic       do_reset;
      logic [7:0] base;
      logic [7:0] step;
      logic [7:0] flip;
      logic       stall;
      logic       exp_done;
      logic       exp_err;
   } vec_t;

   logic clock = 1'b0;
   logic nreset;
   int   errors = 0;
   int   checks = 0;

   always #5 clock = ~clock;

   tile_config_loader_if #(.CONFIG_WIDTH(CW), .WORD_WIDTH(WW)) bus ();

   tile_config_loader #(.CONFIG_WIDTH(CW), .WORD_WIDTH(WW)) dut (
      .clock  (clock),
      .nreset (nreset),
      .bus    (bus)
   );

   task automatic check_bit(input string name, input logic act, input logic exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %b want %b", name, act, exp);
      end
   endtask

   task automatic check_vec(input string name, input logic [PW-1:0] act, input logic [PW-1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h want %h", name, act, exp);
      end
   endtask

   function automatic logic [7:0] word_at(input logic [7:0] base, input logic [7:0] step, input int k);
      return base + 8'(k) * step;
   endfunction

   function automatic logic [PW-1:0] model_cfg(input logic [7:0] base, input logic [7:0] step);
      logic [PW-1:0] r;
      logic [PW-1:0] mask;
      r    = '0;
      mask = '1;
      for (int k = 0; k < NW; k++) r[k*8 +: 8] = word_at(base, step, k);
      mask = mask >> (PW - CW);
      return r & mask;
   endfunction

   function automatic logic [7:0] model_xor(input logic [7:0] base, input logic [7:0] step);
      logic [7:0] x;
      x = 8'h00;
      for (int k = 0; k < NW; k++) x ^= word_at(base, step, k);
      return x;
   endfunction

   // Optional random idle cycles with garbage data, then one valid beat.
   task automatic send_word(input logic [7:0] w, input logic stall);
      if (stall) begin
         repeat ($urandom_range(0, 2)) begin
            bus.data_valid = 1'b0;
            bus.data_in    = 8'($urandom);
            @(posedge clock); #1;
         end
      end
      bus.data_valid = 1'b1;
      bus.data_in    = w;
      @(posedge clock); #1;
      bus.data_valid = 1'b0;
   endtask

   task automatic pulse_start(input logic with_valid, input logic [7:0] w);
      bus.start      = 1'b1;
      bus.data_valid = with_valid;
      bus.data_in    = w;
      @(posedge clock); #1;
      bus.start      = 1'b0;
      bus.data_valid = 1'b0;
   endtask

   task automatic do_reset();
      nreset = 1'b0;
      repeat (2) @(posedge clock);
      #1;
      nreset = 1'b1;
      check_vec("reset_cfg", PW'(bus.config_out), '0);
      check_bit("reset_busy", bus.busy, 1'b0);
      check_bit("reset_ready", bus.data_ready, 1'b0);
      check_bit("reset_done", bus.done, 1'b0);
      check_bit("reset_error", bus.error, 1'b0);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t          vecs [5];
      vec_t          v;
      logic [PW-1:0] cur_cfg;

      vecs[0] = '{1'b1, 8'hA5, 8'h00, 8'h01, 1'b0, 1'b0, 1'b1};
      vecs[1] = '{1'b1, 8'hA5, 8'h00, 8'h00, 1'b0, 1'b1, 1'b0};
      vecs[2] = '{1'b0, 8'hA5, 8'h00, 8'h00, 1'b1, 1'b1, 1'b0};
      vecs[3] = '{1'b0, 8'h10, 8'h03, 8'h00, 1'b0, 1'b1, 1'b0};
      vecs[4] = '{1'b0, 8'h77, 8'h01, 8'h80, 1'b1, 1'b0, 1'b1};

      nreset         = 1'b0;
      bus.start      = 1'b0;
      bus.data_valid = 1'b0;
      bus.data_in    = '0;
      cur_cfg        = '0;

      for (int i = 0; i < 5; i++) begin
         v = vecs[i];
         if (v.do_reset) begin
            do_reset();
            cur_cfg = '0;
         end
         pulse_start(1'b0, 8'h00);
         check_bit("load_busy", bus.busy, 1'b1);
         check_bit("load_ready", bus.data_ready, 1'b1);
         for (int k = 0; k < NW; k++) send_word(word_at(v.base, v.step, k), v.stall);
         check_bit("check_busy", bus.busy, 1'b1);
         check_vec("cfg_before_commit", PW'(bus.config_out), cur_cfg);
         send_word(model_xor(v.base, v.step) ^ v.flip, v.stall);
         if (v.exp_done) cur_cfg = model_cfg(v.base, v.step);
         check_bit("done_pulse", bus.done, v.exp_done);
         check_bit("error_flag", bus.error, v.exp_err);
         check_bit("idle_busy", bus.busy, 1'b0);
         check_bit("idle_ready", bus.data_ready, 1'b0);
         check_vec("cfg_after", PW'(bus.config_out), cur_cfg);
         if (i == 1) check_vec("top_nibble", PW'(bus.config_out[CW-1:CW-4]), PW'(4'h5));
         @(posedge clock); #1;
         check_bit("done_one_cycle", bus.done, 1'b0);
         check_bit("error_sticky", bus.error, v.exp_err);
      end

      // Start clears the sticky error; abort after 30 words, restart word ignored.
      pulse_start(1'b0, 8'h00);
      check_bit("start_clears_error", bus.error, 1'b0);
      for (int k = 0; k < 30; k++) send_word(8'hFF, 1'b0);
      pulse_start(1'b1, 8'hFF);
      check_vec("abort_keeps_cfg", PW'(bus.config_out), cur_cfg);
      for (int k = 0; k < NW; k++) send_word(8'h3C, 1'b0);
      send_word(8'h00, 1'b0);
      cur_cfg = model_cfg(8'h3C, 8'h00);
      check_bit("abort_done", bus.done, 1'b1);
      check_vec("abort_cfg", PW'(bus.config_out), cur_cfg);

      // Reset mid-load after a committed configuration.
      pulse_start(1'b0, 8'h00);
      for (int k = 0; k < 40; k++) send_word(8'h81, 1'b0);
      check_bit("midload_busy", bus.busy, 1'b1);
      nreset = 1'b0;
      @(posedge clock); #1;
      nreset = 1'b1;
      cur_cfg = '0;
      check_vec("midrst_cfg", PW'(bus.config_out), cur_cfg);
      check_bit("midrst_busy", bus.busy, 1'b0);
      check_bit("midrst_ready", bus.data_ready, 1'b0);
      for (int k = 0; k < 30; k++) send_word(8'h81, 1'b0);
      check_bit("ignored_busy", bus.busy, 1'b0);
      check_vec("ignored_cfg", PW'(bus.config_out), cur_cfg);

      // Word presented with start in IDLE is not counted; 67 words follow.
      pulse_start(1'b1, 8'hEE);
      for (int k = 0; k < NW; k++) send_word(word_at(8'h20, 8'h05, k), 1'b0);
      send_word(model_xor(8'h20, 8'h05), 1'b0);
      cur_cfg = model_cfg(8'h20, 8'h05);
      check_bit("collide_done", bus.done, 1'b1);
      check_bit("collide_error", bus.error, 1'b0);
      check_vec("collide_cfg", PW'(bus.config_out), cur_cfg);

      // Valid words in IDLE are refused and leave everything untouched.
      for (int k = 0; k < 5; k++) send_word(8'h55, 1'b0);
      bus.data_valid = 1'b1;
      #1;
      check_bit("idle_ready_low", bus.data_ready, 1'b0);
      bus.data_valid = 1'b0;
      check_bit("idle_busy_low", bus.busy, 1'b0);
      check_vec("idle_cfg_hold", PW'(bus.config_out), cur_cfg);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
